// File: rtl/weight_multiplier_pipe.sv
// Per-PE weight multiplier between the SNC and the SADD.
// Holds one signed weight per source node and absorbs configuration packets.
// Each DATA payload is multiplied by the weight stored for its source.
// The pipeline has valid/ready handshaking and a global stall.
module weight_multiplier_pipe #(
    parameter int unsigned NETWORK_SIZE  = 256,
    parameter int unsigned PAYLOAD_WIDTH = 22,
    parameter int unsigned SEQ_WIDTH     = 4,
    parameter int unsigned TYPE_WIDTH    = 2,
    parameter int unsigned MUL_STAGES    = 2,
    parameter int unsigned PRODUCT_WIDTH = 2 * PAYLOAD_WIDTH,
    parameter int unsigned SATURATE      = 0,
    localparam int unsigned SOURCE_WIDTH = $clog2(NETWORK_SIZE),
    localparam int unsigned PACKET_SIZE  = PAYLOAD_WIDTH + SEQ_WIDTH + 2 * SOURCE_WIDTH
                                           + TYPE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SNC_MUL_valid,
    output logic                     SNC_MUL_ready,
    input  logic [PACKET_SIZE-1:0]   SNC_MUL_packet,
    output logic                     MUL_SADD_valid,
    input  logic                     MUL_SADD_ready,
    output logic [PRODUCT_WIDTH-1:0] MUL_SADD_partialProduct,
    output logic [SOURCE_WIDTH-1:0]  MUL_SADD_source,
    output logic [SEQ_WIDTH-1:0]     MUL_SADD_seq,
    output logic [SOURCE_WIDTH:0]    MUL_SADD_inputNumber
);

    localparam int unsigned FullWidth = 2 * PAYLOAD_WIDTH;

    localparam logic [TYPE_WIDTH-1:0] TypeData     = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] TypeInputNum = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] TypeWeight   = TYPE_WIDTH'(2);

    // Clamp bounds of the signed PRODUCT_WIDTH range, sign-extended to the full width.
    localparam logic signed [FullWidth-1:0] SatMax =
        {{(FullWidth - PRODUCT_WIDTH + 1){1'b0}}, {(PRODUCT_WIDTH - 1){1'b1}}};
    localparam logic signed [FullWidth-1:0] SatMin =
        {{(FullWidth - PRODUCT_WIDTH + 1){1'b1}}, {(PRODUCT_WIDTH - 1){1'b0}}};

    // Packet fields, LSB first: payload, seq, source, dest, type.
    logic [PAYLOAD_WIDTH-1:0] pkt_pay;
    logic [SEQ_WIDTH-1:0]     pkt_seq;
    logic [SOURCE_WIDTH-1:0]  pkt_src;
    logic [SOURCE_WIDTH-1:0]  pkt_dest;
    logic [TYPE_WIDTH-1:0]    pkt_type;

    assign pkt_pay  = SNC_MUL_packet[PAYLOAD_WIDTH-1:0];
    assign pkt_seq  = SNC_MUL_packet[PAYLOAD_WIDTH +: SEQ_WIDTH];
    assign pkt_src  = SNC_MUL_packet[PAYLOAD_WIDTH + SEQ_WIDTH +: SOURCE_WIDTH];
    assign pkt_dest = SNC_MUL_packet[PAYLOAD_WIDTH + SEQ_WIDTH + SOURCE_WIDTH +: SOURCE_WIDTH];
    assign pkt_type = SNC_MUL_packet[PACKET_SIZE-1 -: TYPE_WIDTH];

    // The destination field is not needed inside the PE.
    logic unused_dest;
    assign unused_dest = ^pkt_dest;

    logic stall;
    logic accept;
    logic is_data;
    logic is_inputnum;
    logic is_weight;

    assign stall         = MUL_SADD_valid && !MUL_SADD_ready;
    assign SNC_MUL_ready = !rst && !stall;
    assign accept        = SNC_MUL_valid && SNC_MUL_ready;
    assign is_data       = (pkt_type == TypeData);
    assign is_inputnum   = (pkt_type == TypeInputNum);
    assign is_weight     = (pkt_type == TypeWeight);

    // Weight storage: contents survive reset, only the valid bitmap is cleared.
    logic [PAYLOAD_WIDTH-1:0] weight_mem [NETWORK_SIZE];
    logic [NETWORK_SIZE-1:0]  wvalid_q;
    logic [NETWORK_SIZE-1:0]  wvalid_d;

    // Weight memory write on an accepted CONF_WEIGHT packet.
    always_ff @(posedge clk) begin
        if (accept && is_weight) begin
            weight_mem[pkt_src] <= pkt_pay;
        end
    end

    // Next state of the weight-valid bitmap.
    always_comb begin
        wvalid_d = wvalid_q;
        if (accept && is_weight) begin
            wvalid_d[pkt_src] = 1'b1;
        end
    end

    // Weight-valid bitmap and fan-in count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wvalid_q             <= '0;
            MUL_SADD_inputNumber <= '0;
        end else begin
            wvalid_q <= wvalid_d;
            if (accept && is_inputnum) begin
                MUL_SADD_inputNumber <= pkt_pay[SOURCE_WIDTH:0];
            end
        end
    end

    // Read stage. A CONF_WEIGHT written at the previous edge is already in the
    // memory, so back-to-back write/read needs no bypass. Stalls freeze the read
    // result here so the memory can keep changing underneath.
    logic                            s0_vld_q;
    logic [SOURCE_WIDTH-1:0]         s0_src_q;
    logic [SEQ_WIDTH-1:0]            s0_seq_q;
    logic signed [PAYLOAD_WIDTH-1:0] s0_pay_q;
    logic signed [PAYLOAD_WIDTH-1:0] s0_w_q;

    // Read-stage register, loaded only when the pipeline advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld_q <= 1'b0;
            s0_src_q <= '0;
            s0_seq_q <= '0;
            s0_pay_q <= '0;
            s0_w_q   <= '0;
        end else if (!stall) begin
            s0_vld_q <= accept && is_data;
            s0_src_q <= pkt_src;
            s0_seq_q <= pkt_seq;
            s0_pay_q <= pkt_pay;
            s0_w_q   <= wvalid_q[pkt_src] ? weight_mem[pkt_src] : '0;
        end
    end

    logic signed [FullWidth-1:0] full_prod;
    logic [PRODUCT_WIDTH-1:0]    reduced_prod;

    // Full-precision product reduced to the output width by clamping or wrapping.
    always_comb begin
        full_prod    = s0_pay_q * s0_w_q;
        reduced_prod = full_prod[PRODUCT_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (full_prod > SatMax) begin
                reduced_prod = SatMax[PRODUCT_WIDTH-1:0];
            end else if (full_prod < SatMin) begin
                reduced_prod = SatMin[PRODUCT_WIDTH-1:0];
            end
        end
    end

    logic [MUL_STAGES-1:0]    vld_q;
    logic [PRODUCT_WIDTH-1:0] prod_q [MUL_STAGES];
    logic [SOURCE_WIDTH-1:0]  src_q  [MUL_STAGES];
    logic [SEQ_WIDTH-1:0]     seq_q  [MUL_STAGES];

    // Multiplier pipeline; the last stage drives the SADD interface directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < int'(MUL_STAGES); i++) begin
                prod_q[i] <= '0;
                src_q[i]  <= '0;
                seq_q[i]  <= '0;
            end
        end else if (!stall) begin
            vld_q[0]  <= s0_vld_q;
            prod_q[0] <= reduced_prod;
            src_q[0]  <= s0_src_q;
            seq_q[0]  <= s0_seq_q;
            for (int i = 1; i < int'(MUL_STAGES); i++) begin
                vld_q[i]  <= vld_q[i-1];
                prod_q[i] <= prod_q[i-1];
                src_q[i]  <= src_q[i-1];
                seq_q[i]  <= seq_q[i-1];
            end
        end
    end

    assign MUL_SADD_valid          = vld_q[MUL_STAGES-1];
    assign MUL_SADD_partialProduct = prod_q[MUL_STAGES-1];
    assign MUL_SADD_source         = src_q[MUL_STAGES-1];
    assign MUL_SADD_seq            = seq_q[MUL_STAGES-1];

endmodule

// File: doc/weight_multiplier_pipe.md
Name: weight_multiplier_pipe

Overview:
- Successor to the PE weight multiplier; sits between the spike/neuron controller (SNC) and the sum adder (SADD) inside each PE.
- Stores one signed weight per source node, absorbs configuration packets, and multiplies each data packet payload by the weight for its source.
- Adds valid/ready backpressure, a configurable multiplier pipeline depth, saturation, per-source weight-valid tracking and write-to-read forwarding.

Parameters:
- NETWORK_SIZE, 256: number of nodes; SOURCE_WIDTH = $clog2(NETWORK_SIZE).
- PAYLOAD_WIDTH, 22: signed payload and weight width.
- SEQ_WIDTH, 4: sequence field width.
- TYPE_WIDTH, 2: type field width.
- MUL_STAGES, 2: multiplier pipeline registers; must be >= 1.
- PRODUCT_WIDTH, 2*PAYLOAD_WIDTH: output product width; must be <= 2*PAYLOAD_WIDTH.
- SATURATE, 0: 1 = clamp to the signed PRODUCT_WIDTH range; 0 = keep the low PRODUCT_WIDTH bits (wrap).

Packet layout, LSB first: payload[PAYLOAD_WIDTH], seq, source, dest, type.
PACKET_SIZE = PAYLOAD_WIDTH + SEQ_WIDTH + 2*SOURCE_WIDTH + TYPE_WIDTH.
Type encodings: 2'b00 DATA, 2'b01 CONF_INPUTNUM, 2'b10 CONF_WEIGHT, 2'b11 reserved.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- SNC_MUL_valid  in  1  input packet valid.
- SNC_MUL_ready  out  1  block can accept a packet.
- SNC_MUL_packet  in  PACKET_SIZE  input packet.
- MUL_SADD_valid  out  1  product valid.
- MUL_SADD_ready  in  1  SADD accepts the product.
- MUL_SADD_partialProduct  out  PRODUCT_WIDTH  signed weight*payload.
- MUL_SADD_source  out  SOURCE_WIDTH  source of the product.
- MUL_SADD_seq  out  SEQ_WIDTH  sequence number of the product.
- MUL_SADD_inputNumber  out  SOURCE_WIDTH+1  configured fan-in count, registered.

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- On reset, all outputs are 0 except SNC_MUL_ready, which is 1 once rst deasserts. Pipeline valids, inputNumber and the weight-valid bitmap are cleared.
- Weight memory contents are not reset.
- A packet is accepted when SNC_MUL_valid && SNC_MUL_ready.
- CONF_WEIGHT: write the payload to weight[source] and set wvalid[source]. No output is produced.
- CONF_INPUTNUM: MUL_SADD_inputNumber <= payload[SOURCE_WIDTH:0], visible the cycle after acceptance. No product is produced.
- Reserved type: the packet is consumed and dropped with no side effect.
- DATA read: synchronous weight read at source, taking 1 cycle.
- DATA multiply: signed product through MUL_STAGES registers.
- DATA latency: without stalls, MUL_SADD_valid rises exactly 1+MUL_STAGES cycles after acceptance. seq and source travel alongside the product.
- Unwritten weight (wvalid[source]=0): the product is 0, still emitted with valid.
- Forwarding: a DATA packet accepted the cycle after a CONF_WEIGHT to the same source uses the new weight. Any later DATA also sees it.
- Output is full 2*PAYLOAD_WIDTH signed, then reduced to PRODUCT_WIDTH:
  - SATURATE=1: clamp to [-2^(PRODUCT_WIDTH-1), 2^(PRODUCT_WIDTH-1)-1].
  - SATURATE=0: truncate to the low bits.
- Backpressure is a global stall: stall = MUL_SADD_valid && !MUL_SADD_ready.
- While stalled, every stage holds, outputs stay bit-stable, and SNC_MUL_ready = 0.
- The weight-read stage keeps its read result in a hold register across stalls; no product is lost or duplicated.
- Throughput is 1 packet per cycle when MUL_SADD_ready is held at 1.
- Products leave in acceptance order.
- Bubbles from config packets are not compressed.
- Reset mid-operation discards all in-flight products. The first post-reset output comes only from a post-reset DATA packet.

Test Plan:
- Write weight 3 to src 5, later send DATA src 5 payload -7, seq 4 (MUL_STAGES=2) -> product -21, source 5, seq 4, valid exactly 3 cycles after acceptance.
- CONF_WEIGHT src 9 = 100, then next cycle DATA src 9 payload 2 -> product 200 (forwarding). Before the write, a DATA src 9 gives 0.
- DATA from never-written src 17 after reset -> product 0, valid asserted.
- Three DATA packets back to back with MUL_SADD_ready=0 for 4 cycles after the first valid -> SNC_MUL_ready=0 during the stall, output stable, then 3 products in order with no loss.
- PRODUCT_WIDTH=24, SATURATE=1, weight 2^21-1, payload 2^21-1 -> 8388607. Payload -(2^21) instead -> -8388608. Same case with SATURATE=0 -> low 24 bits of the true product.
- CONF_INPUTNUM payload 37 -> inputNumber=37 next cycle. Assert rst with 2 products in flight -> all outputs 0, no stale valid after release.
